// File: rtl/r5p_soc_uart_fifo.sv
// Buffered CPU-bus bridge to the UART Avalon slave: TX/RX FIFOs plus a small transfer engine.
// Optional build macro R5P_UART_FIFO_THRESHOLD_EN enables a programmable RX interrupt threshold.
module r5p_soc_uart_fifo #(
   parameter int BYTESIZE = 8,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  i_cpu_address,
   input  logic        i_cpu_read,
   input  logic        i_cpu_write,
   input  logic [31:0] i_cpu_writedata,
   output logic [31:0] o_cpu_readdata,
   output logic        o_cpu_waitrequest,
   output logic        o_cpu_interrupt,
   output logic        o_uart_read,
   output logic        o_uart_write,
   output logic [31:0] o_uart_writedata,
   input  logic [31:0] i_uart_readdata,
   input  logic        i_uart_waitrequest,
   input  logic        i_uart_interrupt
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int TX_LW = TX_AW + 1;
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int RX_LW = RX_AW + 1;
   localparam int RX_EW = BYTESIZE + 2;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t                r_state;
   state_t                w_next;

   logic [BYTESIZE-1:0]   r_tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]      r_tx_wptr, r_tx_rptr;
   logic [TX_LW-1:0]      r_tx_level;
   logic [RX_EW-1:0]      r_rx_mem [RX_DEPTH];
   logic [RX_AW-1:0]      r_rx_wptr, r_rx_rptr;
   logic [RX_LW-1:0]      r_rx_level;

   logic                  r_tx_ovf, r_rx_ie, r_tx_ie;
   logic                  r_uart_read, r_uart_write;
   logic [31:0]           r_uart_wdata;

   logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
   logic                  w_wr_data, w_wr_stat, w_wr_ctrl, w_rd_data;
   logic                  w_tx_push, w_tx_pop, w_tx_flush, w_tx_ovf_set;
   logic                  w_rx_push, w_rx_pop, w_rx_flush;
   logic [BYTESIZE-1:0]   w_tx_head;
   logic [RX_EW-1:0]      w_rx_head;
   logic [7:0]            w_tx_lvl8, w_rx_lvl8, w_thr_rd;
   logic                  w_rx_cond;
   logic [31:0]           w_data_rd, w_stat_rd, w_ctrl_rd;
   logic                  w_unused;

   assign w_unused   = ^{i_cpu_writedata, i_uart_readdata};

   assign w_tx_full  = (r_tx_level == TX_LW'(TX_DEPTH));
   assign w_tx_empty = (r_tx_level == '0);
   assign w_rx_full  = (r_rx_level == RX_LW'(RX_DEPTH));
   assign w_rx_empty = (r_rx_level == '0);
   assign w_tx_lvl8  = 8'(r_tx_level);
   assign w_rx_lvl8  = 8'(r_rx_level);
   assign w_tx_head  = r_tx_mem[r_tx_rptr];
   assign w_rx_head  = r_rx_mem[r_rx_rptr];

   assign w_wr_data  = i_cpu_write && (i_cpu_address == 2'd0);
   assign w_wr_stat  = i_cpu_write && (i_cpu_address == 2'd1);
   assign w_wr_ctrl  = i_cpu_write && (i_cpu_address == 2'd2);
   assign w_rd_data  = i_cpu_read  && (i_cpu_address == 2'd0);

   // Fullness is judged on the level before this cycle, so a same-cycle pop cannot rescue the byte
   assign w_tx_push    = w_wr_data && !w_tx_full;
   assign w_tx_ovf_set = w_wr_data &&  w_tx_full;
   assign w_tx_flush   = w_wr_ctrl && i_cpu_writedata[8];
   assign w_rx_flush   = w_wr_ctrl && i_cpu_writedata[9];
   assign w_tx_pop     = (r_state == S_WRITE) && !w_tx_empty;
   assign w_rx_push    = (r_state == S_READ) && i_uart_readdata[31] && !w_rx_full && !w_rx_flush;
   assign w_rx_pop     = w_rd_data && !w_rx_empty;

`ifdef R5P_UART_FIFO_THRESHOLD_EN
   logic [7:0] r_rx_thr;
   logic [7:0] w_thr_eff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_rx_thr <= 8'd1;
      else if (w_wr_ctrl)
         r_rx_thr <= i_cpu_writedata[23:16];
   end

   assign w_thr_eff = (r_rx_thr == 8'd0) ? 8'd1 : r_rx_thr;
   assign w_rx_cond = (w_rx_lvl8 >= w_thr_eff);
   assign w_thr_rd  = r_rx_thr;
`else
   assign w_rx_cond = !w_rx_empty;
   assign w_thr_rd  = 8'd0;
`endif

   assign o_cpu_interrupt   = (r_rx_ie && w_rx_cond) || (r_tx_ie && w_tx_empty);
   assign o_cpu_waitrequest = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_ie  <= 1'b0;
         r_tx_ie  <= 1'b0;
         r_tx_ovf <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_rx_ie <= i_cpu_writedata[0];
            r_tx_ie <= i_cpu_writedata[1];
         end
         if (w_tx_ovf_set)
            r_tx_ovf <= 1'b1;
         else if (w_wr_stat && i_cpu_writedata[31])
            r_tx_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_tx_push)
         r_tx_mem[r_tx_wptr] <= i_cpu_writedata[BYTESIZE-1:0];
   end

   // Flush overrides a coincident engine pop, even in the WRITE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_level <= '0;
      end else if (w_tx_flush) begin
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_level <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_level <= r_tx_level + TX_LW'(1);
            2'b01:   r_tx_level <= r_tx_level - TX_LW'(1);
            default: r_tx_level <= r_tx_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_rx_push)
         r_rx_mem[r_rx_wptr] <= {i_uart_readdata[30], i_uart_readdata[29],
                                 i_uart_readdata[BYTESIZE-1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_level <= '0;
      end else if (w_rx_flush) begin
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_level <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_level <= r_rx_level + RX_LW'(1);
            2'b01:   r_rx_level <= r_rx_level - RX_LW'(1);
            default: r_rx_level <= r_rx_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Received bytes take priority; a byte flushed this cycle is never started
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (i_uart_interrupt && !w_rx_full)
               w_next = S_READ;
            else if (!w_tx_empty && !i_uart_waitrequest && !w_tx_flush)
               w_next = S_WRITE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_uart_read  <= 1'b0;
         r_uart_write <= 1'b0;
         r_uart_wdata <= '0;
      end else begin
         r_uart_read  <= (w_next == S_READ);
         r_uart_write <= (w_next == S_WRITE);
         if (w_next == S_WRITE)
            r_uart_wdata <= 32'(w_tx_head);
      end
   end

   assign o_uart_read      = r_uart_read;
   assign o_uart_write     = r_uart_write;
   assign o_uart_writedata = r_uart_wdata;

   assign w_data_rd = {1'b1, w_rx_head[RX_EW-1], w_rx_head[RX_EW-2],
                       {(29-BYTESIZE){1'b0}}, w_rx_head[BYTESIZE-1:0]};
   assign w_stat_rd = {r_tx_ovf, 7'h00, w_rx_lvl8, w_tx_lvl8, 6'h00, w_rx_full, w_tx_full};
   assign w_ctrl_rd = {8'h00, w_thr_rd, 14'h0000, r_tx_ie, r_rx_ie};

   always_comb begin
      o_cpu_readdata = '0;
      case (i_cpu_address)
         2'd0:    o_cpu_readdata = w_rx_empty ? 32'h0 : w_data_rd;
         2'd1:    o_cpu_readdata = w_stat_rd;
         2'd2:    o_cpu_readdata = w_ctrl_rd;
         default: o_cpu_readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_r5p_soc_uart_fifo.sv
// Scoreboard bench for r5p_soc_uart_fifo: stimulus queues expectations, negedge monitors pop and compare.
module tb_r5p_soc_uart_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  cpu_address = 2'd0;
   logic        cpu_read = 1'b0;
   logic        cpu_write = 1'b0;
   logic [31:0] cpu_writedata = 32'h0;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest, cpu_interrupt;
   logic        uart_read, uart_write;
   logic [31:0] uart_writedata;
   logic [31:0] uart_readdata = 32'h0;
   logic        uart_waitrequest = 1'b0;
   logic        uart_interrupt = 1'b0;

   always #5 clk = ~clk;

   r5p_soc_uart_fifo dut (
      .clk                (clk),
      .rst                (rst),
      .i_cpu_address      (cpu_address),
      .i_cpu_read         (cpu_read),
      .i_cpu_write        (cpu_write),
      .i_cpu_writedata    (cpu_writedata),
      .o_cpu_readdata     (cpu_readdata),
      .o_cpu_waitrequest  (cpu_waitrequest),
      .o_cpu_interrupt    (cpu_interrupt),
      .o_uart_read        (uart_read),
      .o_uart_write       (uart_write),
      .o_uart_writedata   (uart_writedata),
      .i_uart_readdata    (uart_readdata),
      .i_uart_waitrequest (uart_waitrequest),
      .i_uart_interrupt   (uart_interrupt)
   );

`ifdef R5P_UART_FIFO_THRESHOLD_EN
   localparam logic [31:0] CTRL_RST = 32'h0001_0000;
   localparam logic [31:0] CTRL_THR = 32'h0004_0001;
`else
   localparam logic [31:0] CTRL_RST = 32'h0000_0000;
   localparam logic [31:0] CTRL_THR = 32'h0000_0001;
`endif

   typedef struct {
      logic [31:0] data;
      int          cyc;
      string       nm;
   } exp_t;

   exp_t        q_wr[$];
   exp_t        q_rd[$];
   exp_t        q_cpu[$];
   logic [31:0] rx_src[$];

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %08h, required %08h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   // UART slave model: presents the head of rx_src, retires it after the READ cycle
   logic rd_seen = 1'b0;
   always @(negedge clk) rd_seen = uart_read;
   always @(posedge clk) begin
      #2;
      if (rd_seen && rx_src.size() > 0) void'(rx_src.pop_front());
      if (rx_src.size() > 0) begin
         uart_interrupt = 1'b1;
         uart_readdata  = rx_src[0];
      end else begin
         uart_interrupt = 1'b0;
         uart_readdata  = 32'h0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (uart_write) begin
            n_cmp++;
            if (q_wr.size() == 0) begin
               n_err++;
               $display("FAIL uart_write_unexpected: got data %08h, required no strobe (cycle %0d)",
                        uart_writedata, cyc);
            end else begin
               n_cmp--;
               e = q_wr.pop_front();
               check({e.nm, "_data"}, uart_writedata, e.data);
               if (e.cyc >= 0) check({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
         end
         if (uart_read) begin
            n_cmp++;
            if (q_rd.size() == 0) begin
               n_err++;
               $display("FAIL uart_read_unexpected: got strobe, required none (cycle %0d)", cyc);
            end else begin
               n_cmp--;
               e = q_rd.pop_front();
               if (e.cyc >= 0) check({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
               else            check({e.nm, "_strobe"}, 32'(uart_read), 32'd1);
            end
         end
         if (cpu_read && q_cpu.size() > 0) begin
            e = q_cpu.pop_front();
            check(e.nm, cpu_readdata, e.data);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
      cpu_address   = a;
      cpu_writedata = d;
      cpu_write     = 1'b1;
      tick(1);
      cpu_write     = 1'b0;
      cpu_writedata = 32'h0;
   endtask

   task automatic cpu_rd(input logic [1:0] a, input logic [31:0] req, input string nm);
      exp_t e;
      e.data = req; e.cyc = -1; e.nm = nm;
      q_cpu.push_back(e);
      cpu_address = a;
      cpu_read    = 1'b1;
      tick(1);
      cpu_read    = 1'b0;
   endtask

   task automatic exp_write(input logic [7:0] b, input int c, input string nm);
      exp_t e;
      e.data = {24'h0, b}; e.cyc = c; e.nm = nm;
      q_wr.push_back(e);
   endtask

   task automatic exp_read(input int c, input string nm);
      exp_t e;
      e.data = 32'h0; e.cyc = c; e.nm = nm;
      q_rd.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required finish before 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, d, p;
      tick(3);
      check("rst_uart_read",  32'(uart_read), 32'h0);
      check("rst_uart_write", 32'(uart_write), 32'h0);
      check("rst_uart_wdata", uart_writedata, 32'h0);
      check("rst_irq",        32'(cpu_interrupt), 32'h0);
      rst = 1'b0;
      tick(1);
      cpu_rd(2'd1, 32'h0, "rst_status");
      cpu_rd(2'd2, CTRL_RST, "rst_control");
      cpu_rd(2'd0, 32'h0, "rst_data_empty");
      cpu_wr(2'd3, 32'hFFFF_FFFF);
      cpu_rd(2'd3, 32'h0, "addr3_reads_zero");
      check("waitrequest_tied", 32'(cpu_waitrequest), 32'h0);

      // TX ordering and latency
      k = cyc;
      exp_write(8'h55, k + 2, "tx_first");
      cpu_wr(2'd0, 32'h0000_0155);
      cpu_wr(2'd0, 32'h0000_00A3);
      cpu_rd(2'd1, 32'h0000_0200, "tx_level2");
      uart_waitrequest = 1'b1;
      cpu_rd(2'd1, 32'h0000_0100, "tx_level1");
      tick(4);
      uart_waitrequest = 1'b0;
      d = cyc;
      exp_write(8'hA3, d + 1, "tx_second");
      tick(2);
      cpu_rd(2'd1, 32'h0, "tx_level0");

      // TX overflow with the UART held busy
      uart_waitrequest = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_write(8'(8'h10 + i), -1, "tx_ovf_drain");
         cpu_wr(2'd0, 32'(8'h10 + i));
      end
      cpu_rd(2'd1, 32'h8000_1001, "ovf_status");
      cpu_wr(2'd1, 32'h8000_0000);
      cpu_rd(2'd1, 32'h0000_1001, "ovf_cleared");
      uart_waitrequest = 1'b0;
      tick(40);
      cpu_rd(2'd1, 32'h0, "tx_drained");

      // RX path latency
      k = cyc;
      rx_src.push_back(32'h8000_003C);
      exp_read(k + 1, "rx_read");
      tick(1);
      cpu_rd(2'd0, 32'h0, "rx_not_yet");
      cpu_rd(2'd0, 32'h8000_003C, "rx_data");
      cpu_rd(2'd0, 32'h0, "rx_empty_after");
      tick(3);

      // RX full backpressure and overrun-flagged byte
      for (int i = 0; i < 16; i++) begin
         rx_src.push_back(32'h8000_0000 | 32'(i));
         exp_read(-1, "rx_fill");
      end
      rx_src.push_back(32'hC000_00AA);
      tick(50);
      cpu_rd(2'd1, 32'h0010_0002, "rx_full_status");
      p = cyc;
      exp_read(p + 2, "rx_after_pop");
      cpu_rd(2'd0, 32'h8000_0000, "rx_pop0");
      for (int i = 1; i < 16; i++) cpu_rd(2'd0, 32'h8000_0000 | 32'(i), "rx_pop_n");
      cpu_rd(2'd0, 32'hC000_00AA, "rx_overrun_err");
      tick(2);
      cpu_rd(2'd0, 32'h0, "rx_drained");

      // rx_flush coincident with the READ cycle
      k = cyc;
      rx_src.push_back(32'h8000_0077);
      exp_read(k + 1, "flush_read");
      tick(1);
      cpu_wr(2'd2, 32'h0000_0200);
      cpu_rd(2'd1, 32'h0, "flush_status");
      cpu_rd(2'd0, 32'h0, "flush_data");

      // RX interrupt
      cpu_wr(2'd2, 32'h0004_0001);
      cpu_rd(2'd2, CTRL_THR, "ctrl_rw");
`ifdef R5P_UART_FIFO_THRESHOLD_EN
      k = cyc;
      for (int i = 0; i < 4; i++) begin
         rx_src.push_back(32'h8000_0061 + 32'(i));
         exp_read(k + 1 + 2 * i, "thr_read");
      end
      tick(7);
      check("irq_level3", 32'(cpu_interrupt), 32'h0);
      tick(1);
      check("irq_level4", 32'(cpu_interrupt), 32'h1);
      cpu_rd(2'd0, 32'h8000_0061, "thr_pop0");
      check("irq_fall_level3", 32'(cpu_interrupt), 32'h0);
      for (int i = 1; i < 4; i++) cpu_rd(2'd0, 32'h8000_0061 + 32'(i), "thr_pop_n");
`else
      k = cyc;
      rx_src.push_back(32'h8000_0042);
      exp_read(k + 1, "irq_read");
      check("irq_cycle0", 32'(cpu_interrupt), 32'h0);
      tick(1);
      check("irq_cycle1", 32'(cpu_interrupt), 32'h0);
      tick(1);
      check("irq_cycle2", 32'(cpu_interrupt), 32'h1);
      cpu_rd(2'd0, 32'h8000_0042, "irq_pop");
      check("irq_fall", 32'(cpu_interrupt), 32'h0);
`endif
      cpu_wr(2'd2, 32'h0);

      // tx_ie, then reset in the middle of buffered traffic
      uart_waitrequest = 1'b1;
      cpu_wr(2'd2, 32'h0000_0002);
      check("tx_irq_empty", 32'(cpu_interrupt), 32'h1);
      cpu_wr(2'd0, 32'h0000_0099);
      check("tx_irq_pending", 32'(cpu_interrupt), 32'h0);
      cpu_rd(2'd1, 32'h0000_0100, "pre_rst_status");
      rst = 1'b1;
      tick(1);
      check("midrst_uart_write", 32'(uart_write), 32'h0);
      check("midrst_irq", 32'(cpu_interrupt), 32'h0);
      rst = 1'b0;
      uart_waitrequest = 1'b0;
      tick(1);
      cpu_rd(2'd1, 32'h0, "post_rst_status");
      cpu_rd(2'd2, CTRL_RST, "post_rst_control");
      tick(10);

      check("q_wr_left",  32'(q_wr.size()), 32'h0);
      check("q_rd_left",  32'(q_rd.size()), 32'h0);
      check("q_cpu_left", 32'(q_cpu.size()), 32'h0);
      check("rx_src_left", 32'(rx_src.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
